// File: rtl/gcd_vector_sequencer.sv
// Vector store plus playback/check engine for a GCD-style DUT: loads (a, b, expected z)
// triples, issues each one on io_a/io_b/io_e, checks io_z on io_v, and guards every vector with a timeout.
module gcd_vector_sequencer #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 1024,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int TW = $clog2(TIMEOUT)
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             load_en_i,
   input  logic [WIDTH-1:0] load_a_i,
   input  logic [WIDTH-1:0] load_b_i,
   input  logic [WIDTH-1:0] load_exp_i,
   input  logic             clear_i,
   input  logic             start_i,
   output logic [WIDTH-1:0] io_a_o,
   output logic [WIDTH-1:0] io_b_o,
   output logic             io_e_o,
   input  logic [WIDTH-1:0] io_z_i,
   input  logic             io_v_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic             timeout_o,
   output logic             overflow_o,
   output logic [CW-1:0]    vec_count_o,
   output logic [CW-1:0]    mismatch_count_o,
   output logic [IW-1:0]    first_fail_o,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [TW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    vec_count_q, vec_count_d;
   logic [CW-1:0]    mm_q, mm_d;
   logic [IW-1:0]    ff_q, ff_d;
   logic             to_q, to_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] io_a_q, io_a_d;
   logic [WIDTH-1:0] io_b_q, io_b_d;

   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [WIDTH-1:0] mem_e [DEPTH];
   logic             we;
   logic [IW-1:0]    nxt_idx;
   logic             last;

   assign nxt_idx = idx_q + IW'(1);
   assign last    = ((CW'(idx_q) + CW'(1)) == vec_count_q);

   // Operand registers are loaded on entry to ISSUE so they are valid while io_e is high.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      vec_count_d = vec_count_q;
      mm_d        = mm_q;
      ff_d        = ff_q;
      to_d        = to_q;
      ovf_d       = ovf_q;
      io_a_d      = io_a_q;
      io_b_d      = io_b_q;
      we          = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (clear_i) begin
               vec_count_d = '0;
               ovf_d       = 1'b0;
               state_d     = S_IDLE;
            end else if (start_i && (vec_count_q != '0)) begin
               idx_d   = '0;
               mm_d    = '0;
               to_d    = 1'b0;
               ff_d    = '0;
               io_a_d  = mem_a[0];
               io_b_d  = mem_b[0];
               state_d = S_ISSUE;
            end else if (load_en_i) begin
               if (vec_count_q < CW'(DEPTH)) begin
                  we          = 1'b1;
                  vec_count_d = vec_count_q + CW'(1);
                  state_d     = S_IDLE;
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (io_v_i) begin
               if (io_z_i != mem_e[idx_q]) begin
                  mm_d = mm_q + CW'(1);
                  if (mm_q == '0) ff_d = idx_q;
               end
               if (last) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = nxt_idx;
                  io_a_d  = mem_a[nxt_idx];
                  io_b_d  = mem_b[nxt_idx];
                  state_d = S_ISSUE;
               end
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
               to_d = 1'b1;
               if (mm_q == '0) ff_d = idx_q;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         vec_count_q <= '0;
         mm_q        <= '0;
         ff_q        <= '0;
         to_q        <= 1'b0;
         ovf_q       <= 1'b0;
         io_a_q      <= '0;
         io_b_q      <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         vec_count_q <= vec_count_d;
         mm_q        <= mm_d;
         ff_q        <= ff_d;
         to_q        <= to_d;
         ovf_q       <= ovf_d;
         io_a_q      <= io_a_d;
         io_b_q      <= io_b_d;
      end
   end

   // Store contents are not reset; vec_count alone defines which entries are valid.
   always_ff @(posedge clock_i) begin
      if (we) begin
         mem_a[IW'(vec_count_q)] <= load_a_i;
         mem_b[IW'(vec_count_q)] <= load_b_i;
         mem_e[IW'(vec_count_q)] <= load_exp_i;
      end
   end

   assign io_a_o           = io_a_q;
   assign io_b_o           = io_b_q;
   assign io_e_o           = (state_q == S_ISSUE);
   assign busy_o           = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign done_o           = (state_q == S_DONE);
   assign pass_o           = (state_q == S_DONE) && (mm_q == '0) && !to_q;
   assign timeout_o        = to_q;
   assign overflow_o       = ovf_q;
   assign vec_count_o      = vec_count_q;
   assign mismatch_count_o = mm_q;
   assign first_fail_o     = ff_q;
   assign state_o          = state_q;

endmodule

// File: tb/tb_gcd_vector_sequencer.sv
// Bench for gcd_vector_sequencer: behavioural GCD responder with per-vector latency,
// run-level reference model, directed cases and randomized runs.
module tb_gcd_vector_sequencer;
   localparam int WIDTH   = 16;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             load_en = 1'b0;
   logic [WIDTH-1:0] load_a = '0, load_b = '0, load_exp = '0;
   logic             clear = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] io_a, io_b;
   logic             io_e;
   logic [WIDTH-1:0] io_z = '0;
   logic             io_v = 1'b0;
   logic             busy, done, pass, timeout, overflow;
   logic [CW-1:0]    vec_count, mismatch_count;
   logic [IW-1:0]    first_fail;
   logic [1:0]       state;

   gcd_vector_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clock_i(clk), .reset_i(rst), .load_en_i(load_en), .load_a_i(load_a),
      .load_b_i(load_b), .load_exp_i(load_exp), .clear_i(clear), .start_i(start),
      .io_a_o(io_a), .io_b_o(io_b), .io_e_o(io_e), .io_z_i(io_z), .io_v_i(io_v),
      .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
      .overflow_o(overflow), .vec_count_o(vec_count), .mismatch_count_o(mismatch_count),
      .first_fail_o(first_fail), .state_o(state)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Bench-side copy of the store and per-vector responder latency.
   int va [DEPTH];
   int vb [DEPTH];
   int ve [DEPTH];
   int lat [DEPTH];
   int nvec = 0;

   logic [31:0] exp_q[$];
   int vec_seen = 0;
   int e_cnt    = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_total++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
      end
   endtask

   function automatic int gcd(input int a, input int b);
      int x = a, y = b, t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Behavioural GCD DUT: answers L WAIT cycles after the strobe, L from lat[].
   initial begin
      int k = 0, l = 0, res = 0;
      bit pend = 0;
      forever begin
         @(negedge clk);
         io_v = 1'b0;
         if (rst) begin
            pend = 0;
         end else if (io_e) begin
            if (exp_q.size() > 0) chk("issue_ab", {io_a, io_b}, exp_q.pop_front());
            else chk("issue_unexpected", 1, 0);
            l   = (vec_seen < DEPTH) ? lat[vec_seen] : 0;
            res = gcd(int'(io_a), int'(io_b));
            vec_seen++;
            e_cnt++;
            pend = 1;
            k    = 0;
         end else if (pend) begin
            if (k == l) begin
               io_v = 1'b1;
               io_z = WIDTH'(res);
               pend = 0;
            end else begin
               k++;
            end
         end
      end
   end

   task automatic do_load(input int a, input int b, input int e);
      load_a = WIDTH'(a); load_b = WIDTH'(b); load_exp = WIDTH'(e);
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      if (nvec < DEPTH) begin
         va[nvec] = a; vb[nvec] = b; ve[nvec] = e;
         nvec++;
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      nvec = 0;
   endtask

   // Run-level reference: walk the stored vectors in order using the GCD rule.
   task automatic model(output int mm, output bit to, output int ff, output int cyc, output int iss);
      mm = 0; to = 0; ff = 0; cyc = 0; iss = 0;
      for (int i = 0; i < nvec; i++) begin
         iss++;
         if (lat[i] >= TIMEOUT) begin
            to = 1;
            if (mm == 0) ff = i;
            cyc += 1 + TIMEOUT;
            break;
         end
         cyc += 2 + lat[i];
         if (gcd(va[i], vb[i]) != ve[i]) begin
            if (mm == 0) ff = i;
            mm++;
         end
      end
   endtask

   task automatic run(input string tag, input bit meddle);
      int mm, ff, ecyc, iss, cyc;
      bit to;
      model(mm, to, ff, ecyc, iss);
      exp_q.delete();
      for (int i = 0; i < iss; i++) exp_q.push_back({WIDTH'(va[i]), WIDTH'(vb[i])});
      vec_seen = 0;
      e_cnt    = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_e_after_start"}, io_e, 1);
      chk({tag, "_busy"}, busy, 1);
      cyc = 0;
      while (!done && cyc < 200) begin
         if (meddle && cyc == 1) begin
            start = 1'b1; load_en = 1'b1; clear = 1'b1; load_a = 16'h1234;
         end else begin
            start = 1'b0; load_en = 1'b0; clear = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; load_en = 1'b0; clear = 1'b0;
      chk({tag, "_cycles"}, cyc, ecyc);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_pass"}, pass, (mm == 0 && !to));
      chk({tag, "_mm"}, mismatch_count, mm);
      chk({tag, "_timeout"}, timeout, to);
      chk({tag, "_first_fail"}, first_fail, ff);
      chk({tag, "_issued"}, e_cnt, iss);
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
      chk({tag, "_vec_count"}, vec_count, nvec);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) lat[i] = 0;
      #12;
      chk("rst_io_a", io_a, 0);
      chk("rst_io_b", io_b, 0);
      chk("rst_io_e", io_e, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_vec_count", vec_count, 0);
      chk("rst_mm", mismatch_count, 0);
      chk("rst_ff", first_fail, 0);
      chk("rst_state", state, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Passing run with mixed latencies.
      lat[0] = 2; lat[1] = 0; lat[2] = 5;
      do_load(48, 18, 6); do_load(17, 5, 1); do_load(0, 7, 7);
      run("basic", 0);
      run("replay", 0);

      // One wrong expectation.
      do_clear();
      chk("clear_done_low", done, 0);
      lat[0] = 1; lat[1] = 3;
      do_load(48, 18, 5); do_load(20, 8, 4);
      run("mismatch", 0);

      // Responder never answers.
      do_clear();
      lat[0] = 1000;
      do_load(12, 8, 4); do_load(9, 3, 3);
      run("timeout", 0);

      // Answer on the last permitted WAIT cycle is accepted.
      do_clear();
      lat[0] = TIMEOUT - 1;
      do_load(21, 14, 7);
      run("edge_lat", 0);

      // Store overflow, clear, empty start.
      do_clear();
      for (int i = 0; i < 5; i++) do_load(i + 1, 1, 1);
      chk("ovf_count", vec_count, DEPTH);
      chk("ovf_flag", overflow, 1);
      do_clear();
      chk("clr_count", vec_count, 0);
      chk("clr_ovf", overflow, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("empty_start_state", state, 0);
      chk("empty_start_busy", busy, 0);
      chk("empty_start_io_e", io_e, 0);

      // Immediate answers plus controls poked while busy.
      lat[0] = 0; lat[1] = 0;
      do_load(9, 0, 9); do_load(10, 4, 2);
      run("fast_meddle", 1);

      // Reset during WAIT of vector 1.
      do_clear();
      lat[0] = 1; lat[1] = 4;
      do_load(30, 12, 6); do_load(35, 14, 7);
      exp_q.delete();
      exp_q.push_back({16'd30, 16'd12});
      exp_q.push_back({16'd35, 16'd14});
      vec_seen = 0; e_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 50 && !(e_cnt == 2 && !io_e); c++) @(negedge clk);
      chk("midrst_in_wait", state, 2);
      #2 rst = 1'b1;
      #1;
      chk("midrst_io_e", io_e, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_io_a", io_a, 0);
      chk("midrst_count", vec_count, 0);
      chk("midrst_state", state, 0);
      @(negedge clk);
      rst = 1'b0;
      nvec = 0;
      @(negedge clk);
      do_load(30, 12, 6); do_load(35, 14, 7);
      run("after_rst", 0);

      // Randomized runs.
      for (int it = 0; it < 25; it++) begin
         int n;
         do_clear();
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) begin
            int a, b, g;
            a = $urandom_range(0, 400);
            b = $urandom_range(0, 400);
            g = gcd(a, b);
            if ($urandom_range(0, 3) == 0) g = g + 1;
            lat[i] = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
            do_load(a, b, g);
         end
         run($sformatf("rand%0d", it), $urandom_range(0, 1));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
